// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, single-entry IF register with decode
// handshake, and jump/branch redirect with flush of the in-flight instruction.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Addr,
  input  logic [31:0] INST,
  input  logic        stall,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_if_inst, r_if_pc, r_fetch_cnt;
  logic        r_if_valid;

  logic        w_jmp, w_br, w_adv;
  logic [31:0] w_if_pc_p4, w_jmp_tgt, w_br_tgt;

  assign w_if_pc_p4 = r_if_pc + 32'd4;
  assign w_jmp_tgt  = {w_if_pc_p4[31:28], jump_index, 2'b00};
  assign w_br_tgt   = w_if_pc_p4 + {branch_offset[29:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // BOOT lasts exactly one cycle; RUN is absorbing until reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Redirects only apply to a live IF instruction; jump outranks branch,
  // and either outranks stall / decode backpressure
  always_comb begin
    w_jmp = 1'b0;
    w_br  = 1'b0;
    w_adv = 1'b0;
    if (r_state == RUN) begin
      w_jmp = r_if_valid & jump;
      w_br  = r_if_valid & branch_taken & ~jump;
      w_adv = ~w_jmp & ~w_br & ~stall & (~r_if_valid | id_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_if_inst   <= 32'd0;
      r_if_pc     <= 32'd0;
      r_if_valid  <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else if (w_jmp) begin
      r_pc       <= w_jmp_tgt;
      r_if_valid <= 1'b0;
    end else if (w_br) begin
      r_pc       <= w_br_tgt;
      r_if_valid <= 1'b0;
    end else if (w_adv) begin
      r_if_inst   <= INST;
      r_if_pc     <= Addr;
      r_if_valid  <= 1'b1;
      r_pc        <= Addr + 32'd4;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign Addr      = {r_pc[31:2], 2'b00};
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign if_valid  = r_if_valid;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table of per-cycle vectors fed through an expectation
// queue, plus a hand-written asynchronous reset sequence.
module tb_inst_fetch;

  logic        clk, rst_n;
  logic [31:0] Addr, INST, branch_offset, if_inst, if_pc, fetch_cnt;
  logic        stall, id_ready, branch_taken, jump, if_valid;
  logic [25:0] jump_index;

  int errors = 0;
  int checks = 0;

  inst_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .INST(INST), .stall(stall),
    .id_ready(id_ready), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .if_inst(if_inst), .if_pc(if_pc),
    .if_valid(if_valid), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [7:0] idx);
    if (idx == 8'd1) return 32'h00430820;
    return {8'hA5, 16'h0000, idx};
  endfunction

  always_comb INST = romw(Addr[9:2]);

  typedef struct {
    logic        stall, idr, br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ifpc;
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ifpc;
    logic [31:0] cnt;
  } exp_t;

  vec_t vt[24];
  exp_t sb[$];

  function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] o,
                              input logic j, input logic [25:0] x, input logic [31:0] a,
                              input logic v, input logic [31:0] p, input logic [31:0] c);
    vec_t t;
    t.stall = s; t.idr = r; t.br = b; t.off = o; t.jmp = j; t.idx = x;
    t.addr = a; t.vld = v; t.ifpc = p; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".Addr"}, Addr, e.addr);
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, e.vld});
    chk({tag, ".fetch_cnt"}, fetch_cnt, e.cnt);
    if (e.vld) begin
      chk({tag, ".if_pc"}, if_pc, e.ifpc);
      chk({tag, ".if_inst"}, if_inst, romw(e.ifpc[9:2]));
    end
  endtask

  initial begin
    exp_t e;
    // inputs -> state after the edge
    vt[0]  = mk(0,1,0,0,0,0,          32'h00000000,0,32'h0,0);  // BOOT edge: no fetch
    vt[1]  = mk(0,1,0,0,0,0,          32'h00000004,1,32'h0,1);
    vt[2]  = mk(0,1,0,0,0,0,          32'h00000008,1,32'h4,2);
    vt[3]  = mk(0,1,0,0,0,0,          32'h0000000C,1,32'h8,3);
    vt[4]  = mk(1,1,0,0,0,0,          32'h0000000C,1,32'h8,3);
    vt[5]  = mk(1,1,0,0,0,0,          32'h0000000C,1,32'h8,3);
    vt[6]  = mk(1,1,0,0,0,0,          32'h0000000C,1,32'h8,3);
    vt[7]  = mk(0,1,0,0,0,0,          32'h00000010,1,32'hC,4);
    vt[8]  = mk(0,1,0,0,0,0,          32'h00000014,1,32'h10,5);
    vt[9]  = mk(0,1,1,32'hFFFFFFFC,0,0,32'h00000004,0,32'h0,5); // branch back to 0x4
    vt[10] = mk(0,1,1,32'h00000010,0,0,32'h00000008,1,32'h4,6); // branch ignored, IF empty
    vt[11] = mk(0,1,0,0,0,0,          32'h0000000C,1,32'h8,7);
    vt[12] = mk(0,1,0,0,0,0,          32'h00000010,1,32'hC,8);
    vt[13] = mk(0,1,0,0,0,0,          32'h00000014,1,32'h10,9);
    vt[14] = mk(0,1,0,0,0,0,          32'h00000018,1,32'h14,10);
    vt[15] = mk(1,1,1,32'h00000100,1,26'h000010,32'h00000040,0,32'h0,10); // jump wins over branch and stall
    vt[16] = mk(0,0,0,0,0,0,          32'h00000044,1,32'h40,11); // empty IF accepts without id_ready
    vt[17] = mk(0,0,0,0,0,0,          32'h00000044,1,32'h40,11);
    vt[18] = mk(0,0,0,0,0,0,          32'h00000044,1,32'h40,11);
    vt[19] = mk(0,0,1,32'h3BFFFFEF,0,0,32'hF0000000,0,32'h0,11); // wrap-around branch target
    vt[20] = mk(0,1,0,0,0,0,          32'hF0000004,1,32'hF0000000,12);
    vt[21] = mk(0,1,0,0,1,26'h3FFFFFF,32'hFFFFFFFC,0,32'h0,12);
    vt[22] = mk(0,1,0,0,0,0,          32'h00000000,1,32'hFFFFFFFC,13); // PC+4 wraps
    vt[23] = mk(0,1,0,0,0,0,          32'h00000004,1,32'h0,14);

    rst_n = 1'b0; stall = 1'b0; id_ready = 1'b1; branch_taken = 1'b0;
    branch_offset = 32'd0; jump = 1'b0; jump_index = 26'd0;
    #2;
    e = '{32'h0, 1'b0, 32'h0, 32'h0};
    chk_state("reset", e);
    chk("reset.if_inst", if_inst, 32'h0);
    chk("reset.if_pc", if_pc, 32'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      stall = vt[i].stall; id_ready = vt[i].idr; branch_taken = vt[i].br;
      branch_offset = vt[i].off; jump = vt[i].jmp; jump_index = vt[i].idx;
      sb.push_back('{vt[i].addr, vt[i].vld, vt[i].ifpc, vt[i].cnt});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        chk_state($sformatf("vec%0d", i), e);
      end
    end

    // asynchronous reset during stall with a redirect pending
    stall = 1'b1; jump = 1'b1; jump_index = 26'h000020;
    @(negedge clk); rst_n = 1'b0; #1;
    e = '{32'h0, 1'b0, 32'h0, 32'h0};
    chk_state("midrst", e);
    chk("midrst.if_inst", if_inst, 32'h0);
    chk("midrst.if_pc", if_pc, 32'h0);
    stall = 1'b0; jump = 1'b0; id_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = '{32'h0, 1'b0, 32'h0, 32'h0};
    chk_state("post_boot", e);
    @(posedge clk); #1;
    e = '{32'h4, 1'b1, 32'h0, 32'h1};
    chk_state("post_fetch", e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  rising-edge system clock.
REQ-003 SHALL provide port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port Addr  output  32  fetch address to the instruction ROM; the ROM returns the word at Addr[9:2] combinationally in the same cycle.
REQ-005 SHALL provide port INST  input  32  instruction word returned by the ROM for Addr.
REQ-006 SHALL provide port stall  input  1  hazard hold; when 1, no new fetch is accepted.
REQ-007 SHALL provide port id_ready  input  1  decode stage can accept the IF register contents this cycle.
REQ-008 SHALL provide port branch_taken  input  1  taken beq resolved against the instruction currently in the IF register.
REQ-009 SHALL provide port branch_offset  input  32  sign-extended 16-bit beq immediate, in words.
REQ-010 SHALL provide port jump  input  1  j instruction resolved against the instruction currently in the IF register.
REQ-011 SHALL provide port jump_index  input  26  j instruction target field.
REQ-012 SHALL provide port if_inst  output  32  registered fetched instruction.
REQ-013 SHALL provide port if_pc  output  32  registered address of if_inst.
REQ-014 SHALL provide port if_valid  output  1  if_inst/if_pc hold a live instruction.
REQ-015 SHALL provide port fetch_cnt  output  32  count of instructions accepted into the IF register.

Function
REQ-016 SHALL hold a 32-bit PC register; Addr SHALL equal PC combinationally, with Addr[1:0] always 2'b00.
REQ-017 SHALL implement a two-state FSM: BOOT (entered on reset) and RUN.
REQ-018 In BOOT, SHALL perform no fetch and keep if_valid=0; the FSM SHALL move to RUN unconditionally on the next clock edge.
REQ-019 In RUN, "advance" SHALL be (stall==0) AND (if_valid==0 OR id_ready==1).
REQ-020 On advance without redirect, SHALL load if_inst<=INST, if_pc<=PC, if_valid<=1, PC<=PC+4 and fetch_cnt<=fetch_cnt+1 in the same edge; fetch latency is 1 cycle from Addr to if_inst.
REQ-021 When not advancing and with no redirect, SHALL hold PC, if_inst, if_pc and if_valid unchanged; if_valid=1 with id_ready=0 SHALL hold the IF contents indefinitely.
REQ-022 On advance with if_valid=1, id_ready=1 and stall=0, SHALL replace the IF contents in that edge (back-to-back throughput of 1 instruction per cycle).
REQ-023 If jump=1 in RUN: PC<={if_pc_plus4[31:28], jump_index, 2'b00} and if_valid<=0 (flush); no fetch that cycle and fetch_cnt unchanged.
REQ-024 If branch_taken=1 and jump=0 in RUN: PC<=if_pc+4+(branch_offset<<2), truncated to 32 bits, and if_valid<=0 (flush); no fetch and fetch_cnt unchanged.
REQ-025 Priority SHALL be jump > branch_taken > stall > sequential; a redirect SHALL take effect even when stall=1 or id_ready=0.
REQ-026 Redirect inputs SHALL be ignored in BOOT and whenever if_valid=0.
REQ-027 PC+4 from 32'hFFFFFFFC SHALL wrap to 32'h00000000; branch-target arithmetic SHALL wrap modulo 2^32.
REQ-028 fetch_cnt SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, set PC=RESET_PC, if_inst=0, if_pc=0, if_valid=0, fetch_cnt=0 and FSM=BOOT.
REQ-030 Reset asserted mid-operation, including during a stall or redirect, SHALL discard all pending state; the first fetch after release SHALL be from RESET_PC, occurring one cycle after BOOT.

Verification
REQ-031 Reset release with ROM[1]=32'h00430820 and stall=0, id_ready=1 -> Addr sequence 0x0,0x0(BOOT),0x4,0x8; second accepted fetch gives if_pc=0x4, if_inst=32'h00430820; fetch_cnt=2.
REQ-032 stall=1 for 3 cycles with if_pc=0x8 -> PC stays 0xC, if_pc/if_inst are unchanged, fetch_cnt is unchanged; on the cycle stall drops, if_pc=0xC.
REQ-033 if_pc=0x10 with branch_taken=1, branch_offset=32'hFFFFFFFC -> PC=0x4 next cycle, if_valid=0, then if_pc=0x4 on the following cycle.
REQ-034 if_pc=0x14 with jump=1, branch_taken=1, jump_index=26'h000010 -> PC=0x40 (jump wins), if_valid=0.
REQ-035 PC forced to 0xFFFFFFFC via a jump to 26'h3FFFFFF with if_pc[31:28]=4'hF -> next sequential Addr=0x0.
REQ-036 rst_n pulsed low between clock edges while if_valid=1 -> all outputs are 0 immediately, Addr=RESET_PC.
